// File: rtl/decoder_mul_pkg.sv
// Shared constants and stage-1 payload type for the decoder multiplier arbiter.
// Contents:
//   DEC_DIN0_W / DEC_DIN1_W / DEC_DOUT_W - operand and product widths
//   DEC_NUM_REQ / DEC_ID_W                - default requester count and tag width
//   STAT_W                                - per-requester grant counter width
//   s1_t                                  - stage-1 register payload (a, b, id, valid)
package decoder_mul_pkg;

  localparam int unsigned DEC_DIN0_W  = 16;
  localparam int unsigned DEC_DIN1_W  = 11;
  localparam int unsigned DEC_DOUT_W  = 26;
  localparam int unsigned DEC_NUM_REQ = 4;
  localparam int unsigned DEC_ID_W    = $clog2(DEC_NUM_REQ);
  localparam int unsigned STAT_W      = 32;

  typedef struct packed {
    logic signed [DEC_DIN0_W-1:0] a;
    logic [DEC_DIN1_W-1:0]        b;
    logic [DEC_ID_W-1:0]          id;
    logic                         valid;
  } s1_t;

endpackage

// File: rtl/decoder_mul_16s_11ns_26_1_1.sv
// Combinational 16-bit signed x 11-bit unsigned multiplier, low 26 bits kept.
// Ports:
//   din0 - signed operand
//   din1 - unsigned operand
//   dout - wrapped product
module decoder_mul_16s_11ns_26_1_1 #(
  parameter int unsigned din0_WIDTH = 16,
  parameter int unsigned din1_WIDTH = 11,
  parameter int unsigned dout_WIDTH = 26
) (
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout
);

  // Only the low dout_WIDTH bits survive, so the operands are extended to
  // that width (din0 sign-extended, din1 zero-extended) before multiplying.
  logic signed [din0_WIDTH-1:0] a_s;
  logic signed [dout_WIDTH-1:0] a_ext;
  logic        [dout_WIDTH-1:0] b_ext;

  assign a_s   = $signed(din0);
  assign a_ext = dout_WIDTH'(a_s);
  assign b_ext = dout_WIDTH'(din1);
  assign dout  = a_ext * b_ext;

endmodule

// File: rtl/decoder_rr_arb.sv
// Round-robin arbiter: scans req from pointer upward, wrapping modulo NUM_REQ.
// Ports:
//   req     - request vector
//   pointer - highest-priority index this cycle
//   grant   - one-hot grant (zero when no request)
//   idx     - index of the granted requester (0 when no request)
module decoder_rr_arb #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    pointer,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx
);

  int unsigned j;
  logic        found;

  // First set bit at or after the pointer wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = 32'(pointer) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/decoder_mul_arbiter.sv
// Shares one 16s x 11ns -> 26 multiplier among NUM_REQ decoder-layer requesters.
// Round-robin, one accept per cycle, two-stage pipeline, valid/ready response.
// Ports:
//   ap_clk, ap_rst_n     - clock, async active-low reset
//   in_valid / in_ready  - per-requester handshake (in_ready one-hot or zero)
//   in_a / in_b          - packed per-requester operands
//   resp_valid/ready     - response handshake
//   resp_id / resp_data  - requester tag and product
//   stat_grant_cnt       - per-requester saturating accept counters
//                          (only with DECODER_MUL_ARB_STATS_EN defined)
module decoder_mul_arbiter
  import decoder_mul_pkg::*;
#(
  parameter int unsigned NUM_REQ    = DEC_NUM_REQ,
  parameter int unsigned DIN0_WIDTH = DEC_DIN0_W,
  parameter int unsigned DIN1_WIDTH = DEC_DIN1_W,
  parameter int unsigned DOUT_WIDTH = DEC_DOUT_W,
  localparam int unsigned ID_W      = $clog2(NUM_REQ)
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst_n,
  input  logic [NUM_REQ-1:0]               in_valid,
  output logic [NUM_REQ-1:0]               in_ready,
  input  logic [NUM_REQ*DIN0_WIDTH-1:0]    in_a,
  input  logic [NUM_REQ*DIN1_WIDTH-1:0]    in_b,
  output logic                             resp_valid,
  input  logic                             resp_ready,
  output logic [ID_W-1:0]                  resp_id,
  output logic [DOUT_WIDTH-1:0]            resp_data
`ifdef DECODER_MUL_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0]        stat_grant_cnt
`endif
);

  logic [ID_W-1:0]       ptr;
  logic [NUM_REQ-1:0]    grant;
  logic [ID_W-1:0]       win_idx;
  logic                  stall;
  logic                  accept;
  logic [DIN0_WIDTH-1:0] sel_a;
  logic [DIN1_WIDTH-1:0] sel_b;
  logic [DEC_DOUT_W-1:0] prod;
  s1_t                   s1;

  assign stall = resp_valid & ~resp_ready;

  decoder_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (in_valid),
    .pointer (ptr),
    .grant   (grant),
    .idx     (win_idx)
  );

  // Grants are withheld during a stall and while reset is held.
  assign in_ready = (ap_rst_n && !stall) ? grant : '0;
  assign accept   = |(in_valid & in_ready);

  // Operand mux driven by the one-hot grant.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_a = in_a[i*DIN0_WIDTH +: DIN0_WIDTH];
        sel_b = in_b[i*DIN1_WIDTH +: DIN1_WIDTH];
      end
    end
  end

  // Stage 1 capture and round-robin pointer advance.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s1  <= '0;
      ptr <= '0;
    end else if (!stall) begin
      s1.valid <= accept;
      if (accept) begin
        s1.a  <= DEC_DIN0_W'(sel_a);
        s1.b  <= DEC_DIN1_W'(sel_b);
        s1.id <= DEC_ID_W'(win_idx);
        ptr   <= (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + ID_W'(1);
      end
    end
  end

  decoder_mul_16s_11ns_26_1_1 #(
    .din0_WIDTH (DEC_DIN0_W),
    .din1_WIDTH (DEC_DIN1_W),
    .dout_WIDTH (DEC_DOUT_W)
  ) u_mul (
    .din0 (s1.a),
    .din1 (s1.b),
    .dout (prod)
  );

  // Stage 2 response register; data and id hold across bubbles.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
    end else if (!stall) begin
      resp_valid <= s1.valid;
      if (s1.valid) begin
        resp_data <= DOUT_WIDTH'(prod);
        resp_id   <= ID_W'(s1.id);
      end
    end
  end

`ifdef DECODER_MUL_ARB_STATS_EN
  logic [STAT_W-1:0] cnt [NUM_REQ];

  // Saturating per-requester accept counters.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (in_valid[i] && in_ready[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + STAT_W'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign stat_grant_cnt[g*STAT_W +: STAT_W] = cnt[g];
  end
`endif

endmodule

// File: tb/tb_decoder_mul_arbiter.sv
// Directed self-checking bench for decoder_mul_arbiter.
// Build with DECODER_MUL_ARB_STATS_EN defined to also cover the grant counters.
module tb_decoder_mul_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned W0 = 16;
  localparam int unsigned W1 = 11;
  localparam int unsigned WO = 26;

  logic              ap_clk;
  logic              ap_rst_n;
  logic [N-1:0]      in_valid;
  logic [N-1:0]      in_ready;
  logic [N*W0-1:0]   in_a;
  logic [N*W1-1:0]   in_b;
  logic              resp_valid;
  logic              resp_ready;
  logic [1:0]        resp_id;
  logic [WO-1:0]     resp_data;
`ifdef DECODER_MUL_ARB_STATS_EN
  logic [N*32-1:0]   stat_grant_cnt;
`endif

  int n_checks;
  int n_fail;

  // Hand-computed products for the streaming operand set below.
  logic [WO-1:0] exp_p [N];

  decoder_mul_arbiter dut (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data)
`ifdef DECODER_MUL_ARB_STATS_EN
    ,
    .stat_grant_cnt (stat_grant_cnt)
`endif
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W0-1:0] a, input logic [W1-1:0] b);
    in_a[i*W0 +: W0] = a;
    in_b[i*W1 +: W1] = b;
  endtask

  task automatic chk_resp(input string tag, input logic [1:0] id, input logic [WO-1:0] data);
    chk({tag, "_valid"}, 128'(resp_valid), 128'(1'b1));
    chk({tag, "_id"},    128'(resp_id),    128'(id));
    chk({tag, "_data"},  128'(resp_data),  128'(data));
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    ap_rst_n   = 1'b0;
    in_valid   = '1;
    in_a       = '0;
    in_b       = '0;
    resp_ready = 1'b1;
    exp_p[0] = 26'h3FFFFF1;  // -3 * 5
    exp_p[1] = 26'h00037F9;  // 7 * 2047
    exp_p[2] = 26'h00493E0;  // 300 * 1000
    exp_p[3] = 26'h3FFFFFF;  // -1 * 1

    // Reset state, with all requests asserted.
    tick(); tick();
    chk("rst_resp_valid", 128'(resp_valid), 128'(1'b0));
    chk("rst_resp_id",    128'(resp_id),    128'(2'd0));
    chk("rst_resp_data",  128'(resp_data),  128'(26'd0));
    chk("rst_in_ready",   128'(in_ready),   128'(4'b0000));
    in_valid = '0;
    ap_rst_n = 1'b1;

    // Single requester 1: 100 * 2047.
    set_op(1, 16'd100, 11'd2047);
    in_valid = 4'b0010;
    #1 chk("t1_in_ready", 128'(in_ready), 128'(4'b0010));
    tick();
    in_valid = '0;
    chk("t1_lat_valid", 128'(resp_valid), 128'(1'b0));
    tick();
    chk_resp("t1", 2'd1, 26'h0031F9C);

    // Requester 0 wrap case; pointer is 2 so scan wraps to 0.
    set_op(0, 16'h8000, 11'd2047);
    in_valid = 4'b0001;
    #1 chk("t2_in_ready", 128'(in_ready), 128'(4'b0001));
    tick();
    in_valid = '0;
    tick();
    chk_resp("t2", 2'd0, 26'h0008000);
    tick();
    chk("t2_drain_valid", 128'(resp_valid), 128'(1'b0));
    chk("t2_hold_data",   128'(resp_data),  128'(26'h0008000));

    // Reset pointer, then all four streaming.
    #2 ap_rst_n = 1'b0;
    #2 ap_rst_n = 1'b1;
    set_op(0, -16'sd3,  11'd5);
    set_op(1, 16'd7,    11'd2047);
    set_op(2, 16'd300,  11'd1000);
    set_op(3, -16'sd1,  11'd1);
    in_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1 chk($sformatf("rr_grant_%0d", k), 128'(in_ready), 128'(4'b0001 << (k % 4)));
      tick();
      if (k >= 1) chk_resp($sformatf("rr_resp_%0d", k), 2'((k - 1) % 4), exp_p[(k - 1) % 4]);
    end

    // Backpressure for 3 cycles: response 2 in stage 2, request 3 in stage 1.
    resp_ready = 1'b0;
    #1 chk("st_in_ready0", 128'(in_ready), 128'(4'b0000));
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_resp($sformatf("st_hold_%0d", k), 2'd2, exp_p[2]);
      chk($sformatf("st_in_ready_%0d", k), 128'(in_ready), 128'(4'b0000));
    end
    in_valid   = '0;
    resp_ready = 1'b1;
    tick();
    chk_resp("st_rel", 2'd3, exp_p[3]);
    tick();
    chk("st_empty", 128'(resp_valid), 128'(1'b0));

    // Move pointer to 2 with a requester-1 accept, then 0 and 3 contend.
    in_valid = 4'b0010;
    #1 chk("p2_setup", 128'(in_ready), 128'(4'b0010));
    tick();
    in_valid = 4'b1001;
    #1 chk("p2_first", 128'(in_ready), 128'(4'b1000));
    tick();
    chk_resp("p2_r1", 2'd1, exp_p[1]);
    chk("p2_second", 128'(in_ready), 128'(4'b0001));
    tick();
    in_valid = '0;
    chk_resp("p2_r3", 2'd3, exp_p[3]);
    tick();
    chk_resp("p2_r0", 2'd0, exp_p[0]);
    tick();
    chk("p2_empty", 128'(resp_valid), 128'(1'b0));

    // Asynchronous reset mid-stream.
    in_valid = 4'b1111;
    tick(); tick();
    chk("mr_pre_valid", 128'(resp_valid), 128'(1'b1));
    #2 ap_rst_n = 1'b0;
    #1;
    chk("mr_valid", 128'(resp_valid), 128'(1'b0));
    chk("mr_ready", 128'(in_ready),   128'(4'b0000));
    chk("mr_data",  128'(resp_data),  128'(26'd0));
    chk("mr_id",    128'(resp_id),    128'(2'd0));
`ifdef DECODER_MUL_ARB_STATS_EN
    chk("mr_stats", 128'(stat_grant_cnt), 128'(0));
`endif
    in_valid = '0;
    #2 ap_rst_n = 1'b1;
    tick();
    chk("mr_post_valid0", 128'(resp_valid), 128'(1'b0));
    tick();
    chk("mr_post_valid1", 128'(resp_valid), 128'(1'b0));
    in_valid = 4'b1111;
    #1 chk("mr_ptr_zero", 128'(in_ready), 128'(4'b0001));
`ifdef DECODER_MUL_ARB_STATS_EN
    tick();
    tick();
    chk("stat_cnt", 128'(stat_grant_cnt), 128'({32'd0, 32'd0, 32'd1, 32'd1}));
`endif
    in_valid = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder_mul_arbiter.md
Name: decoder_mul_arbiter

Overview:
- Shares a single 16s×11ns→26 multiplier core between NUM_REQ decoder-layer requesters.
- Round-robin arbitration, one accepted request per cycle, two-stage pipeline.
- Each result is returned with its requester ID over a valid/ready response port.
- Sits between the decoder's per-layer MAC sequencers and the multiplier.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- ID_W, $clog2(NUM_REQ), requester tag width (derived; not overridden).
- DIN0_WIDTH, 16, signed activation operand width.
- DIN1_WIDTH, 11, unsigned weight operand width.
- DOUT_WIDTH, 26, product width.

Ports:
- ap_clk  in  1  clock; all state on rising edge.
- ap_rst_n  in  1  reset; asynchronous assert, active-low.
- in_valid  in  NUM_REQ  per-requester request valid.
- in_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- in_a  in  NUM_REQ*DIN0_WIDTH  packed signed operands; requester i at [i*DIN0_WIDTH +: DIN0_WIDTH].
- in_b  in  NUM_REQ*DIN1_WIDTH  packed unsigned operands; same packing.
- resp_valid  out  1  result valid.
- resp_ready  in  1  downstream accept.
- resp_id  out  ID_W  requester index of result.
- resp_data  out  DOUT_WIDTH  product.

Behaviour:
- Reset (ap_rst_n=0, async):
  - s1_valid=0, resp_valid=0, rr pointer=0.
  - resp_id=0, resp_data=0, stat counters=0.
  - in_ready=0 while reset is asserted.
- stall = resp_valid & ~resp_ready. Stall freezes both stages and forces in_ready=0.
- Arbitration (combinational):
  - Scan in_valid starting at the pointer, wrapping modulo NUM_REQ.
  - First set bit wins; grant[i]=1 for the winner.
  - in_ready[i] = grant[i] & ~stall. in_ready depends on in_valid; requesters must not make in_valid depend on in_ready.
- Accept = in_valid[i] & in_ready[i]. On the accept edge:
  - s1_a/s1_b/s1_id ← requester i's operands; s1_valid ← 1.
  - Pointer ← (i+1) mod NUM_REQ.
- Pointer holds when there is no accept, or during a stall.
- Stage 2 when not stalled:
  - resp_valid ← s1_valid.
  - If s1_valid: resp_data ← product(s1_a,s1_b); resp_id ← s1_id.
  - Data/ID hold when s1_valid=0.
- Latency: accept at edge t → resp_valid high after edge t+1. Throughput: 1 result/cycle with resp_ready held high.
- Arithmetic:
  - product = low DOUT_WIDTH bits of $signed(a) * $signed({1'b0,b}).
  - Overflow wraps; no saturation.
- Simultaneous resp handshake and new accept in the same cycle: both occur (pipeline advances).
- All in_valid low: no grant, pointer holds, s1_valid ← 0 when not stalled.
- Single requester continuously valid: it is granted every cycle.
- Reset mid-operation: all in-flight results are discarded; no response is emitted after release until a new accept.

Optional Feature:
- Macro DECODER_MUL_ARB_STATS_EN.
- Defined:
  - Adds output port stat_grant_cnt, NUM_REQ*32 bits, packed per requester.
  - Each 32-bit counter increments on that requester's accept and saturates at 32'hFFFF_FFFF.
  - Cleared by reset.
- Undefined: port and counters absent; function otherwise identical.

Decomposition:
- Package decoder_mul_pkg:
  - DIN0_WIDTH/DIN1_WIDTH/DOUT_WIDTH constants.
  - Stage-1 struct typedef (a, b, id, valid).
  - Stat counter width constant (32).
- Sub-module decoder_rr_arb: NUM_REQ-wide round-robin arbiter.
  - Inputs: req, pointer.
  - Outputs: one-hot grant, winner index.
- Multiplier: instantiate existing decoder_mul_16s_11ns_26_1_1 on the stage-1 registers.

Test Plan:
- Reset, then requester 1 only: a=100, b=2047 → resp_valid two edges after accept; resp_id=1, resp_data=26'h0031F9C.
- Wrap check: requester 0 with a=-32768, b=2047 → resp_data=26'h0008000 (wrapped), resp_id=0.
- All four valid continuously, resp_ready=1 → grants 0,1,2,3,0,… one per cycle; resp_id sequence matches; no bubbles.
- resp_ready=0 for 3 cycles with results in flight → resp_valid/resp_data/resp_id stable, in_ready=0. Release → correct ordered results; nothing lost or duplicated.
- Pointer=2, requesters 0 and 3 valid → requester 3 granted first, then 0.
- Assert ap_rst_n low mid-stream (async, between edges) → resp_valid drops immediately, in_ready drops. After release, pointer=0 and no stale response appears. With STATS_EN, counters read 0.
